// File: rtl/column_merge_pkg.sv
// Shared types and helpers for the column merge block: FSM encoding,
// header column-field width and the round-robin index wrap.
package column_merge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_HRD  = 3'd2,
        ST_HWR  = 3'd3,
        ST_DAT  = 3'd4,
        ST_FIN  = 3'd5
    } state_t;

    // The header carries the column index in its top byte.
    localparam int HDR_COL_WIDTH = 8;

    // Wrap a column index that has stepped at most one lap past the end.
    function automatic int wrap_col(input int col, input int size);
        return (col >= size) ? col - size : col;
    endfunction

endpackage

// File: rtl/column_merge_skid.sv
// Two-entry skid buffer in front of the back FIFO; exposes its occupancy so
// the reader can throttle data reads against words already in flight.
module column_merge_skid
    import column_merge_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic             user_clk,
    input  logic             user_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // NOTE: the storage is deliberately not reset; count and the pointers alone
    // decide which entries are valid, so stale contents are never observed.
    always_ff @(posedge user_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/column_merge.sv
// Drains the per-column info/data FIFO pairs round-robin into the back FIFO,
// one header word plus its data beats per segment, and reports the run length.
module column_merge
    import column_merge_pkg::*;
#(
    parameter int DATA_WIDTH   = 128,
    parameter int COL_MAX_SIZE = 4,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                               user_clk,
    input  logic                               user_rst,
    output logic [COL_MAX_SIZE-1:0]            info_rd_en,
    input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] info_dout,
    input  logic [COL_MAX_SIZE-1:0]            info_empty,
    output logic [COL_MAX_SIZE-1:0]            data_rd_en,
    input  logic [COL_MAX_SIZE*DATA_WIDTH-1:0] data_dout,
    input  logic [COL_MAX_SIZE-1:0]            data_empty,
    output logic [DATA_WIDTH-1:0]              fifo_din,
    output logic                               fifo_wr_en,
    input  logic                               fifo_full,
    input  logic                               paritition_done,
    output logic                               process_done,
    output logic [CNT_WIDTH-1:0]               data_len
);

    localparam int COL_W = (COL_MAX_SIZE > 1) ? $clog2(COL_MAX_SIZE) : 1;

    state_t                 state;
    state_t                 state_next;
    logic [COL_W-1:0]       rr;
    logic [COL_W-1:0]       col;
    logic [COL_W-1:0]       col_inc;
    logic [COL_W-1:0]       pick_col;
    logic [COL_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   any_info;
    logic                   done_latch;
    logic                   clear_pending;
    logic                   len_clear;
    logic                   inflight;
    logic                   data_issue;
    logic                   seg_done;
    logic                   hdr_push;
    logic                   skid_push;
    logic [1:0]             skid_count;
    logic [CNT_WIDTH-1:0]   beats_left;
    logic [DATA_WIDTH-1:0]  info_sel;
    logic [DATA_WIDTH-1:0]  data_sel;
    logic [DATA_WIDTH-1:0]  hdr_next;
    logic [DATA_WIDTH-1:0]  hdr_word;
    logic [DATA_WIDTH-1:0]  skid_din;

    assign any_info = ~&info_empty;
    assign info_sel = info_dout[int'(col)*DATA_WIDTH +: DATA_WIDTH];
    assign data_sel = data_dout[int'(col)*DATA_WIDTH +: DATA_WIDTH];
    assign col_inc  = COL_W'(wrap_col(int'(col) + 1, COL_MAX_SIZE));

    // Walk the columns from the highest offset down so the first non-empty
    // column at or after rr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_col   = '0;
        pick_idx   = '0;
        for (int i = COL_MAX_SIZE - 1; i >= 0; i--) begin
            pick_idx = COL_W'(wrap_col(int'(rr) + i, COL_MAX_SIZE));
            if (!info_empty[pick_idx]) begin
                pick_valid = 1'b1;
                pick_col   = pick_idx;
            end
        end
    end

    // Header keeps the opaque info bits and the beat count; only the top byte
    // is replaced by the column index.
    always_comb begin
        hdr_next = info_sel;
        hdr_next[DATA_WIDTH-1 -: HDR_COL_WIDTH] = HDR_COL_WIDTH'(col);
    end

    // A data read is only issued when the skid is guaranteed room for it on
    // the cycle its data returns.
    assign data_issue = (state == ST_DAT) && !data_empty[col] && (beats_left != '0)
                        && ((skid_count + {1'b0, inflight}) < 2'd2);
    assign seg_done   = (beats_left == '0) && !inflight;
    assign hdr_push   = (state == ST_HWR) && (skid_count != 2'd2);
    assign skid_push  = hdr_push || inflight;
    assign skid_din   = inflight ? data_sel : hdr_word;

    assign fifo_wr_en   = (skid_count != 2'd0) && !fifo_full;
    assign process_done = (state == ST_FIN) && (skid_count == 2'd0);
    assign len_clear    = (state == ST_IDLE) && (state_next == ST_SEL) && clear_pending;

    always_comb begin
        info_rd_en = '0;
        data_rd_en = '0;
        if ((state == ST_SEL) && pick_valid) info_rd_en[pick_col] = 1'b1;
        if (data_issue)                      data_rd_en[col]      = 1'b1;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (any_info || done_latch) state_next = ST_SEL;
            ST_SEL: begin
                if (pick_valid)      state_next = ST_HRD;
                else if (done_latch) state_next = ST_FIN;
                else                 state_next = ST_IDLE;
            end
            ST_HRD:  state_next = ST_HWR;
            ST_HWR:  if (hdr_push) state_next = ST_DAT;
            ST_DAT:  if (seg_done) state_next = ST_SEL;
            ST_FIN:  if (skid_count == 2'd0) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state         <= ST_IDLE;
            rr            <= '0;
            col           <= '0;
            beats_left    <= '0;
            inflight      <= 1'b0;
            done_latch    <= 1'b0;
            clear_pending <= 1'b0;
            data_len      <= '0;
        end else begin
            state    <= state_next;
            inflight <= data_issue;
            // A done pulse landing on the FIN exit survives for the next run.
            done_latch <= paritition_done || (done_latch && !process_done);

            if ((state == ST_SEL) && pick_valid) col <= pick_col;
            if ((state == ST_DAT) && seg_done)   rr  <= col_inc;

            if (state == ST_HRD)  beats_left <= info_sel[CNT_WIDTH-1:0];
            else if (data_issue)  beats_left <= beats_left - CNT_WIDTH'(1);

            if (process_done)     clear_pending <= 1'b1;
            else if (len_clear)   clear_pending <= 1'b0;

            if (len_clear)        data_len <= '0;
            else if (fifo_wr_en)  data_len <= data_len + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge user_clk) begin
        if (state == ST_HRD) hdr_word <= hdr_next;
    end

    column_merge_skid #(
        .WIDTH(DATA_WIDTH)
    ) u_skid (
        .user_clk  (user_clk),
        .user_rst  (user_rst),
        .push      (skid_push),
        .push_data (skid_din),
        .pop       (fifo_wr_en),
        .head      (fifo_din),
        .count     (skid_count)
    );

endmodule

// File: tb/tb_column_merge.sv
// Scoreboard bench for column_merge: FIFO models feed the DUT, expected back
// FIFO words and run lengths are queued by the stimulus and checked by a monitor.
module tb_column_merge;
    import column_merge_pkg::*;

    localparam int DW = 128;
    localparam int NC = 4;
    localparam int CW = 32;

    logic               user_clk = 1'b0;
    logic               user_rst = 1'b1;
    logic [NC-1:0]      info_rd_en;
    logic [NC*DW-1:0]   info_dout = '0;
    logic [NC-1:0]      info_empty = '1;
    logic [NC-1:0]      data_rd_en;
    logic [NC*DW-1:0]   data_dout = '0;
    logic [NC-1:0]      data_empty = '1;
    logic [DW-1:0]      fifo_din;
    logic               fifo_wr_en;
    logic               fifo_full = 1'b0;
    logic               paritition_done = 1'b0;
    logic               process_done;
    logic [CW-1:0]      data_len;

    logic [DW-1:0]      info_q [NC][$];
    logic [DW-1:0]      data_q [NC][$];
    logic [DW-1:0]      exp_q [$];
    logic [CW-1:0]      exp_len_q [$];
    logic [DW-1:0]      info_pend [NC];
    logic [DW-1:0]      data_pend [NC];
    logic [NC-1:0]      info_hit;
    logic [NC-1:0]      data_hit;

    int   checks = 0;
    int   errors = 0;
    int   done_count = 0;
    logic prev_done = 1'b0;
    logic full_toggle = 1'b0;

    always #5 user_clk = ~user_clk;

    column_merge #(
        .DATA_WIDTH  (DW),
        .COL_MAX_SIZE(NC),
        .CNT_WIDTH   (CW)
    ) dut (
        .user_clk       (user_clk),
        .user_rst       (user_rst),
        .info_rd_en     (info_rd_en),
        .info_dout      (info_dout),
        .info_empty     (info_empty),
        .data_rd_en     (data_rd_en),
        .data_dout      (data_dout),
        .data_empty     (data_empty),
        .fifo_din       (fifo_din),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_full      (fifo_full),
        .paritition_done(paritition_done),
        .process_done   (process_done),
        .data_len       (data_len)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] info_word(input int c, input int n);
        return {24'hC0FFEE, 8'(c + 16), 64'h0123_4567_89AB_CDEF, 32'(n)};
    endfunction

    function automatic logic [DW-1:0] hdr_word(input int c, input int n);
        logic [DW-1:0] w;
        w = info_word(c, n);
        w[DW-1 -: 8] = 8'(c);
        return w;
    endfunction

    function automatic logic [DW-1:0] data_word(input int c, input int k);
        return {16'hDA7A, 16'(c), 32'(k), 32'hBEEF_0000, 32'(k) ^ 32'h55};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge user_clk);
            #1;
        end
    endtask

    task automatic give_info(input int c, input int n);
        info_q[c].push_back(info_word(c, n));
    endtask

    task automatic give_data(input int c, input int k0, input int cnt);
        for (int k = k0; k < k0 + cnt; k++) data_q[c].push_back(data_word(c, k));
    endtask

    task automatic expect_seg(input int c, input int n);
        exp_q.push_back(hdr_word(c, n));
        for (int k = 0; k < n; k++) exp_q.push_back(data_word(c, k));
    endtask

    task automatic pulse_done();
        paritition_done = 1'b1;
        step(1);
        paritition_done = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_count < target && n < 2000) begin
            step(1);
            n++;
        end
        if (done_count < target) check("done_timeout", 128'(done_count), 128'(target));
    endtask

    task automatic wait_dat();
        int n = 0;
        while (dut.state != ST_DAT && n < 200) begin
            step(1);
            n++;
        end
        if (dut.state != ST_DAT) check("dat_timeout", 128'(dut.state), 128'(ST_DAT));
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_info_rd_en"}, 128'(info_rd_en), 128'(0));
        check({tag, "_data_rd_en"}, 128'(data_rd_en), 128'(0));
        check({tag, "_fifo_wr_en"}, 128'(fifo_wr_en), 128'(0));
        check({tag, "_process_done"}, 128'(process_done), 128'(0));
        check({tag, "_data_len"}, 128'(data_len), 128'(0));
        check({tag, "_state"}, 128'(dut.state), 128'(ST_IDLE));
    endtask

    // Standard-read FIFO models: rd_en seen before an edge, dout updated after it.
    always begin
        @(negedge user_clk);
        info_hit = '0;
        data_hit = '0;
        for (int c = 0; c < NC; c++) begin
            if (info_rd_en[c]) begin
                check("info_rd_while_empty", 128'(info_empty[c]), 128'(0));
                if (info_q[c].size() > 0) begin
                    info_pend[c] = info_q[c].pop_front();
                    info_hit[c]  = 1'b1;
                end
            end
            if (data_rd_en[c]) begin
                check("data_rd_while_empty", 128'(data_empty[c]), 128'(0));
                if (data_q[c].size() > 0) begin
                    data_pend[c] = data_q[c].pop_front();
                    data_hit[c]  = 1'b1;
                end
            end
        end
        @(posedge user_clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            if (info_hit[c]) info_dout[c*DW +: DW] = info_pend[c];
            if (data_hit[c]) data_dout[c*DW +: DW] = data_pend[c];
            info_empty[c] = (info_q[c].size() == 0);
            data_empty[c] = (data_q[c].size() == 0);
        end
    end

    always begin
        @(posedge user_clk);
        #1;
        fifo_full = full_toggle ? ~fifo_full : 1'b0;
    end

    // Monitor: compare every back-FIFO write and every done pulse.
    always begin
        @(negedge user_clk);
        if (!user_rst) begin
            if (fifo_wr_en) begin
                if (fifo_full)              check("wr_while_full", 128'(fifo_full), 128'(0));
                else if (exp_q.size() == 0) check("extra_word", fifo_din, 128'(0));
                else                        check("word", fifo_din, exp_q.pop_front());
            end
            if (process_done) begin
                check("done_words_left", 128'(exp_q.size()), 128'(0));
                if (exp_len_q.size() == 0) check("unexpected_done", 128'(process_done), 128'(0));
                else                       check("data_len", 128'(data_len), 128'(exp_len_q.pop_front()));
                if (prev_done)             check("done_width", 128'(prev_done), 128'(0));
                done_count++;
            end
            prev_done = process_done;
        end
    end

    initial begin
        user_rst = 1'b1;
        step(3);
        check_quiet("reset");
        user_rst = 1'b0;
        step(2);

        // 1: single segment on column 0
        expect_seg(0, 3);
        exp_len_q.push_back(32'd4);
        give_info(0, 3);
        give_data(0, 0, 3);
        step(2);
        pulse_done();
        wait_done(1);

        // 2: round-robin across 1, 2 (header only) and 3
        expect_seg(1, 2);
        expect_seg(2, 0);
        expect_seg(3, 2);
        exp_len_q.push_back(32'd7);
        give_info(3, 2);
        give_data(3, 0, 2);
        give_info(1, 2);
        give_data(1, 0, 2);
        give_info(2, 0);
        step(2);
        pulse_done();
        wait_done(2);

        // 3: back FIFO full every other cycle
        full_toggle = 1'b1;
        expect_seg(0, 8);
        exp_len_q.push_back(32'd9);
        give_info(0, 8);
        give_data(0, 0, 8);
        step(2);
        pulse_done();
        wait_done(3);
        full_toggle = 1'b0;

        // 4: data FIFO runs dry mid-segment, then refills
        expect_seg(2, 4);
        exp_len_q.push_back(32'd5);
        give_info(2, 4);
        give_data(2, 0, 2);
        step(12);
        check("stall_words_left", 128'(exp_q.size()), 128'(2));
        give_data(2, 2, 2);
        step(2);
        pulse_done();
        wait_done(4);

        // 5: done arrives while the segment is still streaming
        expect_seg(0, 5);
        exp_len_q.push_back(32'd6);
        give_info(0, 5);
        give_data(0, 0, 5);
        wait_dat();
        pulse_done();
        wait_done(5);

        // 6: reset in the middle of a segment, then a fresh run
        expect_seg(0, 5);
        give_info(0, 5);
        give_data(0, 0, 5);
        wait_dat();
        step(1);
        user_rst = 1'b1;
        step(1);
        check_quiet("midrst");
        exp_q.delete();
        info_q[0].delete();
        data_q[0].delete();
        step(1);
        user_rst = 1'b0;
        step(1);
        expect_seg(0, 1);
        exp_len_q.push_back(32'd2);
        give_info(0, 1);
        give_data(0, 0, 1);
        step(2);
        pulse_done();
        wait_done(6);

        step(5);
        check("final_words_left", 128'(exp_q.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
